sram_1rw1r_ctrl: RTL

- Initiator-side controller for the 32x256 1RW+1R OpenRAM macro (sky130_sram_1kbyte_1rw1r_32x256_8).
- Presents two valid/ready request channels to fabric logic:
  - Channel A: read/write, maps to macro port 0.
  - Channel B: read-only, maps to macro port 1.
- Drives the macro's active-low controls, captures dout into per-channel response buffers, and resolves same-address write/read collisions.
- Optionally zero-fills the whole array after reset before accepting traffic.

---
 rtl/sram_ctrl_pkg.sv | 16 +
 rtl/sram_rsp_fifo.sv | 53 +++++
 rtl/sram_1rw1r_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
//   Shared constants and FSM state type for the 1RW+1R SRAM controller.
//   Geometry matches the sky130 32x256 OpenRAM macro.
package sram_ctrl_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int NUM_WMASKS = DATA_W / 8;
    localparam int DEPTH      = 1 << ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo
//   2-entry response FIFO, one per read channel. The head word stays put
//   until popped, so rdata is stable while the consumer stalls.
// Ports:
//   clk, rst_n       clock, async active-low reset (flushes contents)
//   push, push_data  write one word (ignored when full)
//   pop              consumer ready; only takes effect when valid
//   valid, data      head of queue
//   count            occupancy 0..2, used for read credit accounting
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign valid   = (count != 2'd0);
    assign data    = mem[rd_ptr];
    assign push_ok = push && (count != 2'd2);
    assign pop_ok  = pop && valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // Storage needs no reset: count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sram_1rw1r_ctrl.sv
// sram_1rw1r_ctrl
//   Controller for the 32x256 1RW+1R OpenRAM macro.
//   Channel A (read/write) drives macro port 0, channel B (read-only) drives
//   port 1. Read data arrives one edge after accept and lands in a 2-entry
//   per-channel response FIFO; read requests are credit-limited so the FIFO
//   never overflows. Optionally zero-fills the array after reset.
// Ports:
//   clk, rst_n               clock (also macro clk0/clk1), async active-low reset
//   init_busy                high while zero-fill runs
//   a_req_* / a_rsp_*        channel A request / response (valid/ready)
//   b_req_* / b_rsp_*        channel B request / response (valid/ready)
//   csb0/web0/wmask0/addr0/din0/dout0   macro port 0 (active-low controls)
//   csb1/addr1/dout1                    macro port 1
module sram_1rw1r_ctrl #(
    parameter int ADDR_W     = sram_ctrl_pkg::ADDR_W,
    parameter int DATA_W     = sram_ctrl_pkg::DATA_W,
    parameter int NUM_WMASKS = sram_ctrl_pkg::NUM_WMASKS,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_busy,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [NUM_WMASKS-1:0] a_req_wmask,
    input  logic [ADDR_W-1:0]     a_req_addr,
    input  logic [DATA_W-1:0]     a_req_wdata,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_W-1:0]     a_rsp_rdata,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic [ADDR_W-1:0]     b_req_addr,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_W-1:0]     b_rsp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_W-1:0]     addr0,
    output logic [DATA_W-1:0]     din0,
    input  logic [DATA_W-1:0]     dout0,
    output logic                  csb1,
    output logic [ADDR_W-1:0]     addr1,
    input  logic [DATA_W-1:0]     dout1
);

    import sram_ctrl_pkg::*;

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic              run;
    logic              a_infl, b_infl;
    logic [1:0]        a_cnt, b_cnt;
    logic              a_pop, b_pop;
    logic [2:0]        a_occ, b_occ;
    logic              a_acc, a_wr, a_rd, b_acc;
    logic              collide;

    // Gating with rst_n keeps the macro deselected and the fabric stalled
    // for the whole time reset is held, not just after the first edge.
    assign run   = rst_n && (state == ST_RUN);
    assign a_pop = a_rsp_valid && a_rsp_ready;
    assign b_pop = b_rsp_valid && b_rsp_ready;

    // Occupancy the FIFO will have after the next edge; a same-cycle pop
    // frees a slot immediately.
    assign a_occ = {1'b0, a_cnt} + {2'b0, a_infl} - {2'b0, a_pop};
    assign b_occ = {1'b0, b_cnt} + {2'b0, b_infl} - {2'b0, b_pop};

    assign a_req_ready = run && (a_req_we || (a_occ < 3'd2));
    assign a_acc       = a_req_valid && a_req_ready;
    assign a_wr        = a_acc && a_req_we;
    assign a_rd        = a_acc && !a_req_we;

    // Port 1 would read stale data if it hit the word port 0 writes this
    // edge, so B is held off one cycle and re-reads the new value.
    assign collide     = a_wr && (a_req_addr == b_req_addr);
    assign b_req_ready = run && (b_occ < 3'd2) && !collide;
    assign b_acc       = b_req_valid && b_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT_ZERO ? ST_INIT : ST_RUN;
            init_cnt <= '0;
            a_infl   <= 1'b0;
            b_infl   <= 1'b0;
        end else begin
            state  <= state_nxt;
            a_infl <= a_rd;
            b_infl <= b_acc;
            if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        init_busy = 1'b0;
        csb0      = 1'b1;
        web0      = 1'b1;
        wmask0    = '0;
        addr0     = '0;
        din0      = '0;
        csb1      = 1'b1;
        addr1     = '0;
        case (state)
            ST_INIT: begin
                init_busy = 1'b1;
                if (rst_n) begin
                    csb0   = 1'b0;
                    web0   = 1'b0;
                    wmask0 = '1;
                    addr0  = init_cnt;
                end
                if (init_cnt == {ADDR_W{1'b1}}) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (a_acc) begin
                    csb0  = 1'b0;
                    web0  = !a_req_we;
                    addr0 = a_req_addr;
                    if (a_req_we) begin
                        wmask0 = a_req_wmask;
                        din0   = a_req_wdata;
                    end
                end
                if (b_acc) begin
                    csb1  = 1'b0;
                    addr1 = b_req_addr;
                end
            end
            default: ;
        endcase
    end

    sram_rsp_fifo #(.DW(DATA_W)) u_a_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (a_infl),
        .push_data (dout0),
        .pop       (a_rsp_ready),
        .valid     (a_rsp_valid),
        .data      (a_rsp_rdata),
        .count     (a_cnt)
    );

    sram_rsp_fifo #(.DW(DATA_W)) u_b_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (b_infl),
        .push_data (dout1),
        .pop       (b_rsp_ready),
        .valid     (b_rsp_valid),
        .data      (b_rsp_rdata),
        .count     (b_cnt)
    );

endmodule
